// File: rtl/qif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qif_pkg
// Purpose  : Shared types, default constants and helpers for the QIF array.
// Revision : 1.0 - initial release
// ============================================================================
package qif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_DEF_W      = 8;
    localparam int c_DEF_NCH    = 4;
    localparam int c_DEF_VRESET = -20;
    localparam int c_DEF_VPEAK  = 50;
    localparam int c_DEF_VSH    = 3;
    localparam int c_DEF_BSH    = 2;
    localparam int c_DEF_REFR   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic longint sat_w(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qif_update_core.sv
`default_nettype none
// ============================================================================
// Module   : qif_update_core
// Purpose  : Combinational single-channel QIF update (square, input, saturate,
//            threshold); refractory handling when QIF_REFRACTORY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module qif_update_core
    import qif_pkg::*;
#(
    parameter int W      = c_DEF_W,
    parameter int VRESET = c_DEF_VRESET,
    parameter int VPEAK  = c_DEF_VPEAK,
    parameter int VSH    = c_DEF_VSH,
`ifdef QIF_REFRACTORY_EN
    parameter int REFR   = c_DEF_REFR,
    parameter int CW     = 2,
`endif
    parameter int BSH    = c_DEF_BSH
) (
    input  logic signed [W-1:0]  v_i,
    input  logic signed [W-1:0]  b_i,
`ifdef QIF_REFRACTORY_EN
    input  logic        [CW-1:0] cnt_i,
    output logic        [CW-1:0] cnt_new_o,
`endif
    output logic signed [W-1:0]  v_new_o,
    output logic                 spike_o
);

    localparam int c_IW = 2 * W + 2;
    localparam logic signed [W-1:0]    c_VRST = W'(VRESET);
    localparam logic signed [c_IW-1:0] c_PEAK = c_IW'(VPEAK);

    logic signed [c_IW-1:0] w_v_ext;
    logic signed [c_IW-1:0] w_b_ext;
    logic signed [c_IW-1:0] w_vs;
    logic signed [c_IW-1:0] w_sq;
    logic signed [c_IW-1:0] w_bs;
    logic signed [c_IW-1:0] w_sum;
    logic signed [W-1:0]    w_vnext;
    logic signed [c_IW-1:0] w_vnext_ext;
    logic                   w_fire;

    assign w_v_ext     = {{(c_IW - W){v_i[W-1]}}, v_i};
    assign w_b_ext     = {{(c_IW - W){b_i[W-1]}}, b_i};
    assign w_vs        = w_v_ext >>> VSH;
    assign w_sq        = w_vs * w_vs;
    assign w_bs        = w_b_ext >>> BSH;
    assign w_sum       = w_v_ext + w_sq + w_bs;
    assign w_vnext     = W'(sat_w(longint'(w_sum), W));
    assign w_vnext_ext = {{(c_IW - W){w_vnext[W-1]}}, w_vnext};
    // Threshold is applied to the saturated potential.
    assign w_fire      = (w_vnext_ext >= c_PEAK);

`ifdef QIF_REFRACTORY_EN
    always_comb begin
        v_new_o   = w_vnext;
        spike_o   = 1'b0;
        cnt_new_o = cnt_i;
        if (cnt_i != '0) begin
            v_new_o   = c_VRST;
            cnt_new_o = cnt_i - CW'(1);
        end else if (w_fire) begin
            v_new_o   = c_VRST;
            spike_o   = 1'b1;
            cnt_new_o = CW'(REFR);
        end
    end
`else
    always_comb begin
        v_new_o = w_vnext;
        spike_o = 1'b0;
        if (w_fire) begin
            v_new_o = c_VRST;
            spike_o = 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/qif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : qif_neuron_array
// Purpose  : Time-multiplexed array of NCH QIF neurons sharing one update core.
//            Optional refractory period enabled by defining QIF_REFRACTORY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int W      = c_DEF_W,
    parameter int NCH    = c_DEF_NCH,
    parameter int VRESET = c_DEF_VRESET,
    parameter int VPEAK  = c_DEF_VPEAK,
    parameter int VSH    = c_DEF_VSH,
    parameter int BSH    = c_DEF_BSH,
    parameter int REFR   = c_DEF_REFR,
    localparam int AW    = (clog2(NCH) > 0) ? clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_i,
    input  logic [NCH*W-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NCH-1:0]       spike_o,
    input  logic [AW-1:0]        rd_addr_i,
    output logic signed [W-1:0]  v_rd_o
);

    localparam logic signed [W-1:0] c_VRST = W'(VRESET);
    localparam logic [AW-1:0]       c_LAST = AW'(NCH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_idx;
    logic signed [W-1:0] r_v [NCH];
    logic [NCH-1:0]      r_acc;
    logic [NCH-1:0]      w_acc_nxt;
    logic [NCH-1:0]      r_spike;
    logic                w_last;
    logic signed [W-1:0] w_v_cur;
    logic signed [W-1:0] w_b_cur;
    logic signed [W-1:0] w_v_new;
    logic                w_spike;

    assign w_last  = (r_idx == c_LAST);
    assign w_v_cur = r_v[r_idx];
    assign w_b_cur = b_i[r_idx*W +: W];

`ifdef QIF_REFRACTORY_EN
    localparam int CW = (clog2(REFR + 1) > 0) ? clog2(REFR + 1) : 1;

    logic [CW-1:0] r_cnt [NCH];
    logic [CW-1:0] w_cnt_new;

    qif_update_core #(
        .W      (W),
        .VRESET (VRESET),
        .VPEAK  (VPEAK),
        .VSH    (VSH),
        .REFR   (REFR),
        .CW     (CW),
        .BSH    (BSH)
    ) u_core (
        .v_i       (w_v_cur),
        .b_i       (w_b_cur),
        .cnt_i     (r_cnt[r_idx]),
        .cnt_new_o (w_cnt_new),
        .v_new_o   (w_v_new),
        .spike_o   (w_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (r_state == RUN) begin
            r_cnt[r_idx] <= w_cnt_new;
        end
    end
`else
    qif_update_core #(
        .W      (W),
        .VRESET (VRESET),
        .VPEAK  (VPEAK),
        .VSH    (VSH),
        .BSH    (BSH)
    ) u_core (
        .v_i     (w_v_cur),
        .b_i     (w_b_cur),
        .v_new_o (w_v_new),
        .spike_o (w_spike)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (step_i) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_acc_nxt        = r_acc;
        w_acc_nxt[r_idx] = w_spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (r_state == RUN && !w_last) begin
            r_idx <= r_idx + AW'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // spike_o is loaded together with the final channel so it is already
    // valid in the cycle that done_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_spike <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_v[k] <= c_VRST;
            end
        end else if (r_state == RUN) begin
            r_v[r_idx] <= w_v_new;
            r_acc      <= w_acc_nxt;
            if (w_last) begin
                r_spike <= w_acc_nxt;
            end
        end
    end

    assign busy_o  = (r_state == RUN);
    assign done_o  = (r_state == DONE);
    assign spike_o = r_spike;

    generate
        if ((2 ** AW) > NCH) begin : g_rd_guard
            assign v_rd_o = (rd_addr_i < AW'(NCH)) ? r_v[rd_addr_i] : '0;
        end else begin : g_rd_full
            assign v_rd_o = r_v[rd_addr_i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_qif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_qif_neuron_array
// Purpose  : Scoreboard bench for qif_neuron_array with directed sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qif_neuron_array;

    typedef struct {
        logic [31:0] v;
        logic [3:0]  spike;
        int          step_cyc;
        string       name;
    } sweep_t;

    typedef struct {
        logic [31:0] v;
        logic [3:0]  spike;
        logic        busy;
        string       name;
    } chk_t;

    logic              clk;
    logic              rst_n;
    logic              step_i;
    logic [31:0]       b_i;
    logic              busy_o;
    logic              done_o;
    logic [3:0]        spike_o;
    logic [1:0]        rd_addr_i;
    logic signed [7:0] v_rd_o;

    int compared;
    int mismatched;
    int cyc;

    sweep_t q_sw[$];
    chk_t   q_chk[$];

    qif_neuron_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (step_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .spike_o   (spike_o),
        .rd_addr_i (rd_addr_i),
        .v_rd_o    (v_rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared = compared + 1;
        if (act != exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic read_all(input string name, input logic [31:0] exp_v);
        logic [7:0] e;
        for (int k = 0; k < 4; k++) begin
            rd_addr_i = 2'(k);
            #1;
            e = exp_v[k*8 +: 8];
            check($sformatf("%s.v%0d", name, k), int'(v_rd_o), int'($signed(e)));
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents a result.
    initial begin
        sweep_t s;
        chk_t   c;
        rd_addr_i = '0;
        forever begin
            @(negedge clk);
            if (done_o) begin
                if (q_sw.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    s = q_sw.pop_front();
                    check({s.name, ".latency"}, cyc - s.step_cyc, 5);
                    check({s.name, ".spike"}, int'(spike_o), int'(s.spike));
                    read_all(s.name, s.v);
                end
            end else if (q_chk.size() > 0) begin
                c = q_chk.pop_front();
                check({c.name, ".busy"}, int'(busy_o), int'(c.busy));
                check({c.name, ".spike"}, int'(spike_o), int'(c.spike));
                read_all(c.name, c.v);
            end
        end
    end

    task automatic set_b(input int b0, input int b1, input int b2, input int b3);
        b_i = pack4(b0, b1, b2, b3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_chk(input string name, input logic [31:0] v,
                            input logic [3:0] spike, input logic busy);
        chk_t c;
        c.name = name; c.v = v; c.spike = spike; c.busy = busy;
        q_chk.push_back(c);
    endtask

    task automatic wait_chk();
        int n;
        n = 0;
        while (q_chk.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q_chk.size() > 0) begin
            check("chk_timeout", q_chk.size(), 0);
            q_chk.delete();
        end
    endtask

    task automatic issue_step(input string name, input logic [31:0] v, input logic [3:0] spike);
        sweep_t s;
        @(negedge clk);
        s.name = name; s.v = v; s.spike = spike; s.step_cyc = cyc;
        q_sw.push_back(s);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
    endtask

    task automatic wait_sweeps();
        int n;
        n = 0;
        while (q_sw.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q_sw.size() > 0) begin
            check("done_timeout", q_sw.size(), 0);
            q_sw.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        step_i     = 1'b0;
        b_i        = '0;
        #2;
        do_reset();

        // Reset state
        push_chk("reset", pack4(-20, -20, -20, -20), 4'b0000, 1'b0);
        wait_chk();

        // Drift with zero input
        issue_step("drift", pack4(-11, -11, -11, -11), 4'b0000);
        wait_sweeps();

        // Spike on channel 1, then refractory behaviour on later sweeps
        do_reset();
        set_b(0, 127, 0, 0);
        issue_step("spk1", pack4(-11, 20, -11, -11), 4'b0000);
        wait_sweeps();
        issue_step("spk2", pack4(-7, -20, -7, -7), 4'b0010);
        wait_sweeps();
`ifdef QIF_REFRACTORY_EN
        issue_step("spk3", pack4(-6, -20, -6, -6), 4'b0000);
        wait_sweeps();
        issue_step("spk4", pack4(-5, -20, -5, -5), 4'b0000);
        wait_sweeps();
`else
        issue_step("spk3", pack4(-6, 20, -6, -6), 4'b0000);
        wait_sweeps();
        issue_step("spk4", pack4(-5, -20, -5, -5), 4'b0010);
        wait_sweeps();
`endif
        issue_step("spk5", pack4(-4, 20, -4, -4), 4'b0000);
        wait_sweeps();

        // Negative input saturating the shifted B term range
        do_reset();
        set_b(0, 0, -128, 0);
        issue_step("neg", pack4(-11, -11, -43, -11), 4'b0000);
        wait_sweeps();

        // step_i during RUN and during DONE must be ignored
        do_reset();
        set_b(0, 0, 0, 0);
        issue_step("ign", pack4(-11, -11, -11, -11), 4'b0000);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        repeat (12) @(negedge clk);
        check("ign_pending", q_sw.size(), 0);
        push_chk("ign_after", pack4(-11, -11, -11, -11), 4'b0000, 1'b0);
        wait_chk();

        // Abort by asynchronous reset mid-sweep
        do_reset();
        set_b(0, 127, 0, 0);
        issue_step("spk_pre", pack4(-11, 20, -11, -11), 4'b0000);
        wait_sweeps();
        issue_step("abort", pack4(0, 0, 0, 0), 4'b0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q_sw.delete();
        push_chk("abort", pack4(-20, -20, -20, -20), 4'b0000, 1'b0);
        wait_chk();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
